countdown_timer: RTL and testbench
==================================

# countdown_timer

Synchronous loadable seconds down-counter, the counterpart to the day-length ripple up-counter.

- Loaded with a duration in ticks (0…86399), it decrements once per `tick` strobe.
- It raises a one-cycle `expired` pulse on reaching zero.
- It sits beside the up-counter in the timer subsystem and provides alarm and interval timing in the same one-second tick domain.

## Interface
Parameters:
- `CNT_W`, default 17: counter width; must hold `MAX_TICKS`.
- `MAX_TICKS`, default 86399: largest loadable value (one day minus one tick).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on rising edge.
- `clr`  in  1  asynchronous active-low reset; clears all state immediately.
- `tick`  in  1  one-cycle-wide count-enable strobe (nominally 1 Hz), synchronous to `clk`.
- `load`  in  1  load `load_val` into the counter.
- `load_val`  in  CNT_W  duration in ticks.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting.
- `count`  out  CNT_W  current remaining ticks (registered).
- `busy`  out  1  high while in RUN.
- `paused`  out  1  high while in PAUSE.
- `expired`  out  1  one-cycle pulse at terminal count.

## Operation
States, encoded 2-bit:
- IDLE = 0
- RUN = 1
- PAUSE = 2
- DONE = 3

Input priority, high to low: `clr`, `load`, `stop`, `start`, `tick`.

Load:
- `load` is accepted in any state and always moves to IDLE.
- `count` takes `min(load_val, MAX_TICKS)`.
- The same saturated value is stored in the internal `reload_val` register.

Start:
- In IDLE with `count != 0`, `start` moves to RUN.
- In IDLE with `count == 0`, `start` is ignored and the block stays IDLE.
- In PAUSE, `start` moves to RUN.
- In DONE, `start` is ignored.

Stop:
- In RUN, `stop` moves to PAUSE; `count` is held.
- In any other state, `stop` has no effect.

Counting in RUN:
- On each `tick` with `count > 1`: `count` decrements by 1.
- On a `tick` with `count == 1`:
  - `count` becomes 0.
  - State moves to DONE.
  - `expired` is asserted for exactly the cycle in which `count` first reads 0.

Hold behaviour:
- `tick` is ignored in IDLE, PAUSE and DONE.
- DONE holds `count = 0` until `load`.

Width and arithmetic:
- No wrap-around: `count` never decrements below 0 and never exceeds `MAX_TICKS`.
- All arithmetic is unsigned, CNT_W bits wide.

Outputs:
- `busy` = (state == RUN).
- `paused` = (state == PAUSE).
- Both are decoded from the state register, so they carry no extra latency.

## Timing
Reset values (while `clr` = 0):
- `count` = 0, `reload_val` = 0.
- state = IDLE.
- `busy` = 0, `paused` = 0, `expired` = 0.

Latency:
- `load`, `start` and `stop` take effect on the first rising edge at which they are sampled high.
- Their results are visible on outputs one cycle later.
- Decrement latency from a `tick` to the updated `count` is 1 cycle.

Simultaneous events:
- `stop` and `tick` in the same RUN cycle: no decrement.
- `load` and `tick` together: load wins.
- `start` and `tick` in IDLE: the state goes to RUN, but that tick does not decrement; the first decrement happens on the next tick.

Other timing rules:
- `tick` held high for N consecutive cycles in RUN decrements N times; the bench must not rely on edge detection.
- Reset mid-run: `clr` low forces reset values asynchronously. Any pending `expired` pulse is lost.
- Release of `clr` is assumed to be synchronised upstream.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - At terminal count in RUN, `count` takes `reload_val` instead of 0.
  - State stays RUN and `expired` still pulses for one cycle.
  - `count` never reads 0 while running periodically.
  - DONE is unreachable except via a `reload_val` of 0, which cannot start.
- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - One-shot behaviour as described under Operation.
  - The `reload_val` register is still present but only feeds nothing and may be optimised away.

## Structure
- Package `timer_pkg` holds:
  - `DAY_TICKS` = 86400.
  - `CNT_W` = 17.
  - `MAX_TICKS` = `DAY_TICKS` − 1.
  - Typedef `cnt_t` (`logic [CNT_W-1:0]`).
  - Enum `cd_state_e` {IDLE, RUN, PAUSE, DONE}.
- The same package is shared with the up-counter for `DAY_TICKS`.
- Single module; no sub-module is warranted. The FSM and datapath are one `always_ff` plus a next-state `always_comb`.

## Test plan
- Reset: assert `clr` = 0 mid-RUN with `count` = 500 → `count` = 0, `busy` = 0, state IDLE immediately, with no clock edge needed.
- Basic expiry: `load_val` = 3, load, start, then 3 ticks → `count` 3→2→1→0, `expired` high exactly one cycle with `count` = 0, state DONE. Further ticks leave `count` = 0 and `expired` low.
- Saturation and start guard:
  - `load_val` = 100000 → `count` = 86399.
  - `load_val` = 0, then start → state stays IDLE, `busy` = 0.
- Pause and priority:
  - In RUN at `count` = 10, assert `stop` and `tick` together → `count` stays 10, `paused` = 1.
  - Then `start` → RUN; the next tick gives `count` = 9.
- Load during RUN: `count` = 7, `load` with `load_val` = 20 together with a tick → `count` = 20, state IDLE, no decrement.
- Autoreload (macro defined): load 2, start, 6 ticks → `count` 2,1,2,1,2,1.
  - `expired` pulses on ticks 2, 4 and 6.
  - `busy` stays 1 throughout.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: constants, count type and FSM states shared by the one-second tick timers.
package timer_pkg;
    localparam int DAY_TICKS = 86400;
    localparam int CNT_W     = 17;
    localparam int MAX_TICKS = DAY_TICKS - 1;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} cd_state_e;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable tick down-counter with one-cycle expired pulse.
// COUNTDOWN_AUTORELOAD_EN makes it periodic by reloading reload_val at terminal count.
module countdown_timer #(
    parameter int CNT_W     = timer_pkg::CNT_W,
    parameter int MAX_TICKS = timer_pkg::MAX_TICKS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             expired
);
    import timer_pkg::*;

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_RUN   = RUN;
    localparam logic [1:0]       ST_PAUSE = PAUSE;
    localparam logic [1:0]       ST_DONE  = DONE;
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_TICKS);

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] count_d, reload_val, reload_d, sat_val;
    logic             expired_d;

    assign sat_val = (load_val > MAX_C) ? MAX_C : load_val;
    assign busy    = state == ST_RUN;
    assign paused  = state == ST_PAUSE;

    // Priority chain: load, stop, start, tick; a stop/start that has no effect falls through.
    always_comb begin
        state_d   = state;
        count_d   = count;
        reload_d  = reload_val;
        expired_d = 1'b0;
        if (load) begin
            state_d  = ST_IDLE;
            count_d  = sat_val;
            reload_d = sat_val;
        end else if (stop && state == ST_RUN) begin
            state_d = ST_PAUSE;
        end else if (start && ((state == ST_IDLE && count != '0) || state == ST_PAUSE)) begin
            state_d = ST_RUN;
        end else if (tick && state == ST_RUN) begin
            if (count > CNT_W'(1)) begin
                count_d = count - CNT_W'(1);
            end else begin
                expired_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_d = reload_val;
`else
                count_d = '0;
                state_d = ST_DONE;
`endif
            end
        end
    end

`ifndef COUNTDOWN_AUTORELOAD_EN
    logic unused_reload;
    assign unused_reload = ^reload_val;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_val <= '0;
            expired    <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            reload_val <= reload_d;
            expired    <= expired_d;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboarded random and directed checks against a behavioural timer model.
module tb_countdown_timer;
    localparam int MAX = 86399;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [16:0] load_val = '0;
    logic [16:0] count;
    logic        busy, paused, expired;

    countdown_timer dut (
        .clk(clk), .clr(clr), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .count(count), .busy(busy), .paused(paused),
        .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        bit run;
        bit pau;
        bit exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_cnt, m_rel;
    bit m_run, m_pause, m_done, m_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_pause = 0; m_done = 0; m_exp = 0;
    endfunction

    function automatic void model_step(bit l, int lv, bit st, bit sp, bit tk);
        m_exp = 0;
        if (l) begin
            m_cnt = (lv > MAX) ? MAX : lv;
            m_rel = m_cnt;
            m_run = 0; m_pause = 0; m_done = 0;
        end else if (sp && m_run) begin
            m_run = 0; m_pause = 1;
        end else if (st && (m_pause || (!m_run && !m_done && m_cnt != 0))) begin
            m_run = 1; m_pause = 0;
        end else if (tk && m_run) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_exp = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                m_cnt = m_rel;
`else
                m_run = 0; m_done = 1;
`endif
            end
        end
    endfunction

    task automatic drv(bit l, int lv, bit st, bit sp, bit tk);
        @(negedge clk);
        load = l; load_val = 17'(lv); start = st; stop = sp; tick = tk;
        model_step(l, lv, st, sp, tk);
        q.push_back('{cyc + 1, m_cnt, m_run, m_pause, m_exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; stop = 0; tick = 0; load_val = '0;
    endtask

    always @(posedge clk) begin
        #2;
        while (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_count", int'(count), e.cnt);
            chk("sb_busy", int'(busy), int'(e.run));
            chk("sb_paused", int'(paused), int'(e.pau));
            chk("sb_expired", int'(expired), int'(e.exp));
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_expired", int'(expired), 0);
        @(negedge clk);
        clr = 1'b1;

        drv(1, 3, 0, 0, 0);  chk("load3", int'(count), 3);
        drv(0, 0, 1, 0, 0);  chk("start_busy", int'(busy), 1);
        drv(0, 0, 0, 0, 1);  chk("tick_2", int'(count), 2);
        drv(0, 0, 0, 0, 1);  chk("tick_1", int'(count), 1);
        chk("no_exp_early", int'(expired), 0);
        drv(0, 0, 0, 0, 1);
        chk("tick_0", int'(count), 0);
        chk("exp_pulse", int'(expired), 1);
`ifndef COUNTDOWN_AUTORELOAD_EN
        chk("done_busy", int'(busy), 0);
        drv(0, 0, 0, 0, 1);
        chk("done_hold", int'(count), 0);
        chk("exp_once", int'(expired), 0);
        drv(0, 0, 1, 0, 1);
        chk("done_start_ign", int'(busy), 0);
`endif

        drv(1, 100000, 0, 0, 0);  chk("saturate", int'(count), MAX);
        drv(1, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0);       chk("zero_no_start", int'(busy), 0);

        drv(1, 10, 0, 0, 0);
        drv(0, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 1);
        chk("stop_tick_cnt", int'(count), 10);
        chk("stop_paused", int'(paused), 1);
        drv(0, 0, 0, 0, 1);       chk("pause_tick_ign", int'(count), 10);
        drv(0, 0, 1, 0, 0);       chk("resume_busy", int'(busy), 1);
        drv(0, 0, 0, 0, 1);       chk("resume_tick", int'(count), 9);

        drv(1, 7, 0, 0, 0);
        drv(0, 0, 1, 0, 0);
        drv(1, 20, 0, 0, 1);
        chk("load_wins", int'(count), 20);
        chk("load_idle", int'(busy), 0);

        drv(1, 5, 0, 0, 0);
        drv(0, 0, 1, 0, 1);
        chk("start_tick_cnt", int'(count), 5);
        chk("start_tick_busy", int'(busy), 1);
        drv(0, 0, 0, 0, 1);       chk("first_dec", int'(count), 4);

        drv(1, 500, 0, 0, 0);
        drv(0, 0, 1, 0, 0);
        #4;
        idle_inputs();
        clr = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_paused", int'(paused), 0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit l, st, sp, tk;
            int lv;
            l  = ($urandom_range(0, 99) < 4);
            st = ($urandom_range(0, 99) < 20);
            sp = ($urandom_range(0, 99) < 5);
            tk = ($urandom_range(0, 99) < 55);
            lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(86390, 131071))
                                             : int'($urandom_range(0, 12));
            drv(l, lv, st, sp, tk);
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
